// File: rtl/seq_detector_param.sv
// Serial pattern detector with overlap/non-overlap modes and a match counter.
// Optional macro SEQ_DET_CNT_SAT_EN: Counter saturates instead of wrapping.
module seq_detector_param #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stream,
  input  logic             Valid,
  input  logic             Overlap,
  input  logic             Clear,
  output logic             Tone,
  output logic [CNT_W-1:0] Counter,
  output logic             o_dbg_state
);

  typedef enum logic {FILLING = 1'b0, ARMED = 1'b1} state_t;

  localparam int             FW   = $clog2(PATTERN_W + 1);
  localparam logic [FW-1:0]  FULL = FW'(PATTERN_W);

  state_t               r_state;
  logic [PATTERN_W-1:0] r_hist;
  logic [FW-1:0]        r_fill;
  logic                 r_tone;
  logic [CNT_W-1:0]     r_cnt;

  state_t               w_state_nxt;
  logic [PATTERN_W-1:0] w_hist_shift;
  logic [PATTERN_W-1:0] w_hist_nxt;
  logic [FW-1:0]        w_fill_inc;
  logic [FW-1:0]        w_fill_nxt;
  logic                 w_match;
  logic                 w_tone_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;

  // Valid/handshake: a sample is consumed on every rising edge where Valid=1;
  // there is no back-pressure, the detector accepts one bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILLING;
      r_hist  <= '0;
      r_fill  <= '0;
      r_tone  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_tone  <= w_tone_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_hist_shift = {r_hist[PATTERN_W-2:0], Stream};
    w_fill_inc   = (r_state == ARMED) ? FULL : r_fill + FW'(1);
    w_match      = Valid && (w_fill_inc == FULL) && (w_hist_shift == PATTERN);
    w_hist_nxt   = r_hist;
    w_fill_nxt   = r_fill;
    if (Valid) begin
      w_hist_nxt = w_hist_shift;
      // Non-overlapping mode restarts the fill so the next match needs fresh bits.
      w_fill_nxt = (w_match && !Overlap) ? '0 : w_fill_inc;
    end
    w_state_nxt = (w_fill_nxt == FULL) ? ARMED : FILLING;
  end

  always_comb begin
    w_tone_nxt = w_match;
    w_cnt_nxt  = r_cnt;
    if (Clear) begin
      w_cnt_nxt = '0;
    end else if (w_match) begin
`ifdef SEQ_DET_CNT_SAT_EN
      if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
`else
      w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
    end
  end

  assign Tone        = r_tone;
  assign Counter     = r_cnt;
  assign o_dbg_state = r_state;

endmodule
